// File: rtl/ram_stream_reader_if.sv
// Byte stream interface: valid/ready handshake plus an end-of-burst tag.
// The master drives valid/data/last and the slave drives ready.
interface ram_stream_reader_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of bytes from one read-only port of the
// 8-bit dual-port RAM and emits them as a valid/ready stream.
//
// A 2-entry skid FIFO absorbs the 1-cycle RAM read latency. When the FIFO is
// empty the byte arriving from the RAM is presented directly (bypass), which
// gives start -> ram_en -> m.valid latencies of one cycle each and a sustained
// rate of one byte per cycle. Reads are throttled so that reads in flight plus
// bytes held never exceed 2, so backpressure never drops or re-reads a byte.
//
// Optional feature (macro READER_CSUM_EN): when defined, csum is the sum mod
// 256 of every handshaked byte of the current/last burst; when undefined the
// accumulator is not built and csum reads 8'h00.
module ram_stream_reader #(
  parameter int DP = 512,
  parameter int AW = $clog2(DP) - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW:0]         base_addr,
  input  logic [AW+1:0]       len,
  output logic                busy,
  output logic                done,
  output logic                ram_en,
  output logic [AW:0]         ram_addr,
  input  logic [7:0]          ram_dout,
  ram_stream_reader_if.master m,
  output logic [7:0]          csum
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_ST
  } state_t;

  localparam logic [AW:0]   LAST_ADDR = (AW+1)'(DP - 1);
  localparam logic [AW+1:0] CNT_ONE   = (AW+2)'(1);

  state_t        state_q, state_d;

  logic [AW:0]   addr_q;
  logic [AW+1:0] issue_cnt_q;

  // Read issued last cycle: its data is on ram_dout this cycle.
  logic          inflight_q;
  logic          inflight_last_q;

  // Skid FIFO: 2 entries of {last tag, byte}.
  logic [7:0]    fifo_data [2];
  logic          fifo_last [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;

  logic          accept;
  logic          fifo_empty;
  logic          handshake;
  logic          push;
  logic          pop;
  logic [1:0]    occupancy;

  // Stream head selection, handshake and FIFO push/pop decisions.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values just computed; registers below use '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_comb begin
    fifo_empty = (count_q == 2'd0);
    accept     = (state_q == IDLE) && start;
    occupancy  = 2'(inflight_q) + count_q;

    if (!fifo_empty) begin
      m.valid = 1'b1;
      m.data  = fifo_data[rd_ptr_q];
      m.last  = fifo_last[rd_ptr_q];
    end else begin
      m.valid = inflight_q;
      m.data  = inflight_q ? ram_dout : 8'h00;
      m.last  = inflight_q & inflight_last_q;
    end

    handshake = m.valid && m.ready;
    // An arriving byte bypasses the FIFO only if it is the head and is taken.
    push      = inflight_q && !(fifo_empty && handshake);
    pop       = handshake && !fifo_empty;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    ram_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len != '0) ? RUN : DONE_ST;
        end
      end
      RUN: begin
        busy   = 1'b1;
        ram_en = (issue_cnt_q != '0) && (occupancy < 2'd2);
        if (handshake && m.last) begin
          state_d = DONE_ST;
        end
      end
      DONE_ST: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_addr = addr_q;

  // Read address / remaining-read counter and the in-flight read tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= ram_en;
      inflight_last_q <= ram_en && (issue_cnt_q == CNT_ONE);
      if (accept && (len != '0)) begin
        addr_q      <= base_addr;
        issue_cnt_q <= len;
      end else if (ram_en) begin
        addr_q      <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q - 1'b1;
      end
    end
  end

  // Skid FIFO storage: captures the RAM byte and its last tag.
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read while count_q says it holds a written byte, and the pointers/count
  // below are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= ram_dout;
      fifo_last[wr_ptr_q] <= inflight_last_q;
    end
  end

  // Skid FIFO pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef READER_CSUM_EN
  logic [7:0] csum_q;

  // Checksum: cleared on an accepted start, accumulates every accepted beat,
  // and therefore holds its value from the done pulse to the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else if (accept) begin
      csum_q <= 8'h00;
    end else if (handshake) begin
      csum_q <= csum_q + m.data;
    end
  end

  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed testbench for ram_stream_reader. A behavioural RAM preloaded with
// ram[i] = i[7:0] supplies data with a 1-cycle registered read. Expected
// bytes, addresses, tags and checksums are hand-derived for each burst.
module tb_ram_stream_reader;

  localparam int DP = 512;
  localparam int AW = $clog2(DP) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   base_addr;
  logic [AW+1:0] len;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic [AW:0]   ram_addr;
  logic [7:0]    ram_dout = 8'h00;
  logic [7:0]    csum;

  logic [7:0]    ram [DP];

  int checks = 0;
  int errors = 0;

  ram_stream_reader_if m_if ();

  ram_stream_reader #(.DP(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m         (m_if),
    .csum      (csum)
  );

  always #5 clk = ~clk;

  // RAM read port with registered output.
  always @(posedge clk) begin
    if (ram_en) ram_dout <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_csum(input string tag, input logic [7:0] exp);
`ifdef READER_CSUM_EN
    check(tag, 32'(csum), 32'(exp));
`else
    check(tag, 32'(csum), 32'h0);
`endif
  endtask

  // Runs one burst. Cycle 0 is the cycle start is high. toggle selects the
  // 1,0,0,1,0,1 ready pattern; restart pulses a second start at cycle 3;
  // abort_after > 0 returns right after that many beats were accepted.
  task automatic run_burst(input string name, input logic [AW:0] b, input logic [AW+1:0] n,
                           input bit toggle, input bit restart, input int abort_after,
                           input logic [7:0] exp_csum);
    int         k, issued, first_en, first_beat, last_beat, done_cyc, done_cnt, max_occ, occ, a;
    bit         busy_seen, busy_at_done, stalled, held_last;
    logic [7:0] held_data;
    logic [5:0] pat;
    pat = 6'b101001;
    k = 0; issued = 0; first_en = -1; first_beat = -1; last_beat = -1;
    done_cyc = -1; done_cnt = 0; max_occ = 0;
    busy_seen = 1'b0; busy_at_done = 1'b0; stalled = 1'b0; held_last = 1'b0; held_data = 8'h00;

    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (restart && cyc == 3);
      if (cyc == 0) begin
        base_addr = b;
        len       = n;
      end else if (restart && cyc == 3) begin
        base_addr = 9'h100;
        len       = 10'd2;
      end
      m_if.ready = toggle ? pat[cyc % 6] : 1'b1;
      @(negedge clk);

      occ = issued - k;
      if (occ > max_occ) max_occ = occ;
      if (busy) busy_seen = 1'b1;

      if (stalled) begin
        check({name, " stall_valid"}, 32'(m_if.valid), 32'h1);
        check({name, " stall_data"},  32'(m_if.data),  32'(held_data));
        check({name, " stall_last"},  32'(m_if.last),  32'(held_last));
      end

      if (ram_en) begin
        if (first_en < 0) first_en = cyc;
        a = (int'(b) + issued) % DP;
        check({name, " ram_addr"}, 32'(ram_addr), 32'(a));
        issued++;
      end

      if (m_if.valid && m_if.ready) begin
        a = (int'(b) + k) % DP;
        check({name, " data"}, 32'(m_if.data), 32'(a[7:0]));
        check({name, " last"}, 32'(m_if.last), 32'(k == int'(n) - 1));
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        k++;
        if (abort_after > 0 && k == abort_after) return;
      end
      stalled   = m_if.valid && !m_if.ready;
      held_data = m_if.data;
      held_last = m_if.last;

      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
    end

    check({name, " done_seen"},   32'(done_cyc >= 0), 32'h1);
    check({name, " beats"},       32'(k),        32'(n));
    check({name, " reads"},       32'(issued),   32'(n));
    check({name, " done_pulses"}, 32'(done_cnt), 32'h1);
    check({name, " occ_over_2"},  32'(max_occ > 2), 32'h0);
    check({name, " busy_at_done"}, 32'(busy_at_done), 32'h0);
    if (n != '0) begin
      check({name, " first_en_cyc"}, 32'(first_en), 32'h1);
      check({name, " done_after_last"}, 32'(done_cyc), 32'(last_beat + 1));
      check({name, " busy_seen"}, 32'(busy_seen), 32'h1);
      if (!toggle) begin
        check({name, " first_beat_cyc"}, 32'(first_beat), 32'h2);
        check({name, " no_gap"}, 32'(last_beat - first_beat), 32'(int'(n) - 1));
      end
    end else begin
      check({name, " done_cyc"},   32'(done_cyc), 32'h1);
      check({name, " no_read"},    32'(first_en),   32'hFFFF_FFFF);
      check({name, " no_beat"},    32'(first_beat), 32'hFFFF_FFFF);
      check({name, " busy_seen"},  32'(busy_seen), 32'h0);
    end
    check_csum({name, " csum"}, exp_csum);
  endtask

  initial begin
    int done_cnt;
    for (int i = 0; i < DP; i++) ram[i] = 8'(i);
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_if.ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset busy",     32'(busy),       32'h0);
    check("reset done",     32'(done),       32'h0);
    check("reset ram_en",   32'(ram_en),     32'h0);
    check("reset ram_addr", 32'(ram_addr),   32'h0);
    check("reset m_valid",  32'(m_if.valid), 32'h0);
    check("reset m_data",   32'(m_if.data),  32'h0);
    check("reset m_last",   32'(m_if.last),  32'h0);
    check("reset csum",     32'(csum),       32'h0);

    // 10+11+12+13 = 0x46
    run_burst("basic",   9'h010, 10'd4, 1'b0, 1'b0, 0, 8'h46);
    // FE+FF+00+01 = 0x1FE -> 0xFE
    run_burst("wrap",    9'h1FE, 10'd4, 1'b0, 1'b0, 0, 8'hFE);
    // 8*0x20 + 28 = 0x11C -> 0x1C
    run_burst("toggle",  9'h020, 10'd8, 1'b1, 1'b0, 0, 8'h1C);
    run_burst("len0",    9'h033, 10'd0, 1'b0, 1'b0, 0, 8'h00);
    // 6*0x50 + 15 = 0x1EF -> 0xEF
    run_burst("restart", 9'h050, 10'd6, 1'b0, 1'b1, 0, 8'hEF);

    // Reset after the 3rd accepted byte of a 10-byte burst.
    run_burst("abort",   9'h080, 10'd10, 1'b0, 1'b0, 3, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort busy",     32'(busy),       32'h0);
    check("abort done",     32'(done),       32'h0);
    check("abort ram_en",   32'(ram_en),     32'h0);
    check("abort ram_addr", 32'(ram_addr),   32'h0);
    check("abort m_valid",  32'(m_if.valid), 32'h0);
    check("abort m_data",   32'(m_if.data),  32'h0);
    check("abort m_last",   32'(m_if.last),  32'h0);
    check("abort csum",     32'(csum),       32'h0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'h0);

    // C0+C1 = 0x181 -> 0x81
    run_burst("after_rst", 9'h0C0, 10'd2, 1'b0, 1'b0, 0, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Downstream consumer of the team's 8-bit dual-port RAM: drives one RAM port in read-only mode (en/addr, 1-cycle registered read data) and emits a burst of bytes as a valid/ready stream.
- A burst is described by a base address and a length; the address wraps at DP.
- A 2-entry skid buffer absorbs the RAM read latency, so the stream runs at full rate under arbitrary backpressure without losing bytes.

Parameters:
- DP, 512, RAM depth in bytes; must match the attached RAM instance.
- AW, $clog2(DP)-1, MSB index of the address bus.

Ports:
- clk  in  1  single clock for all logic, shared with the RAM port used.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle request to begin a burst; sampled only in IDLE.
- base_addr  in  AW+1  first RAM address of the burst; sampled with start.
- len  in  AW+2  byte count, 0..DP; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at burst completion.
- ram_en  out  1  RAM port enable; high only in cycles that issue a read.
- ram_addr  out  AW+1  RAM read address.
- ram_dout  in  8  RAM registered read data, valid 1 cycle after ram_en.
- m_valid  out  1  stream data valid.
- m_data  out  8  stream byte.
- m_last  out  1  high with the final byte of the burst.
- m_ready  in  1  downstream accept.
- csum  out  8  burst checksum (see Optional Feature).

Behaviour:
- Reset values: busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, csum=0; FSM in IDLE; skid buffer empty.
- FSM states:
  - IDLE: start=1 and len!=0 -> RUN; load addr=base_addr and issue_cnt=len.
  - IDLE: start=1 and len==0 -> DONE_ST; no RAM access, no beats.
  - RUN: last beat handshaked (m_valid & m_ready & m_last) -> DONE_ST.
  - DONE_ST: assert done for one cycle -> IDLE. busy is low in IDLE and DONE_ST.
- start is ignored while not in IDLE.
- Issue rule in RUN: ram_en=1 when issue_cnt>0 and (inflight + buffered) < 2, where inflight is the number of reads issued last cycle.
  - On issue: addr <= (addr==DP-1) ? 0 : addr+1; issue_cnt decrements.
- Data path:
  - ram_dout is captured into the skid FIFO the cycle after ram_en=1.
  - m_data/m_valid present the FIFO head. A handshake pops the head.
  - A pop and a push in the same cycle are legal; FIFO occupancy is then unchanged.
- Latency: start at cycle 0 -> first ram_en at cycle 1 -> m_valid at cycle 2.
- Throughput: with m_ready held high, 1 byte/cycle sustained.
- m_last is asserted only with byte index len-1. Its tag travels with the data through the FIFO.
- Backpressure: while m_valid=1 and m_ready=0, m_data, m_last and m_valid must stay stable. Reads stop once 2 bytes are held or in flight, so no byte is dropped or read twice.
- len==DP: the full RAM is read once, wrapping from DP-1 to 0 if base_addr!=0.
- Reset mid-burst: everything returns to reset values next cycle; the partial burst is abandoned and no done pulse is generated.

Optional Feature:
- Macro: READER_CSUM_EN.
- Defined: csum accumulates the sum mod 256 of every handshaked byte in the burst. It clears on an accepted start and is held stable from the done pulse until the next accepted start. For len==0, csum=0.
- Undefined: the accumulator is not built and csum is tied to 8'h00.

Test Plan:
- RAM preloaded with ram[i]=i; start with base=0x010, len=4, m_ready=1 -> bytes 10,11,12,13 on consecutive cycles from cycle 2; m_last on 0x13; done pulse 1 cycle after the last beat; csum=0x46 when the macro is defined.
- base=0x1FE, len=4, DP=512 -> addresses 1FE,1FF,000,001; data FE,FF,00,01 with no gap.
- len=8, m_ready toggled 1,0,0,1,0,1,... -> exactly 8 bytes in order, m_data stable while stalled, and inflight+buffered never exceeds 2.
- start with len=0 -> no ram_en, no m_valid, done pulses 1 cycle later, busy stays 0.
- start pulsed again mid-burst with a different base -> ignored, original burst completes unchanged.
- rst asserted after the 3rd byte of a len=10 burst -> next cycle all outputs 0 and state IDLE; no done pulse; a new start with len=2 works normally.
